// File: rtl/lcd_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780 write sequencer: state
//               encoding, power-up init ROM contents and the command codes
//               that need the long post-write wait.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_IDLE    = 3'd4
  } lcd_state_e;

  // Power-up init sequence, written in this order.
  localparam int         INIT_LEN      = 4;
  localparam logic [7:0] INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] INIT_CLEAR    = 8'h01;  // clear display
  localparam logic [7:0] INIT_ENTRY    = 8'h06;  // increment, no shift

  // Commands the controller needs ~1.64 ms to execute.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // True when the byte just written needs the long post-write wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_sequencer_if
// Description : Single-byte write request handshake between the CPU control
//               unit (master) and the LCD write sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_write_sequencer_if;

  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );

endinterface
`default_nettype wire

// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_sequencer
// Description : Owns the HD44780 character LCD bus. Runs the power-up init
//               sequence after reset, then performs single-byte writes for
//               the control unit with setup, E-pulse and busy-wait timing.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_AS      = 2,
  parameter int T_EH      = 25,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 20
) (
  input  wire                        clk,
  input  wire                        reset,
  lcd_write_sequencer_if.slave       req,
  input  wire                        soft_reinit,
  output logic                       init_done,
  output logic                       busy,
  output logic [7:0]                 lcd_data,
  output logic                       lcd_rs,
  output logic                       lcd_rw,
  output logic                       lcd_e
);

  // Terminal counts: the shared counter runs 0 .. T-1 in each timed state.
  localparam logic [CNT_W-1:0] PU_LAST    = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] AS_LAST    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] EH_LAST    = CNT_W'(T_EH - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);
  localparam logic [1:0]       INIT_LAST  = 2'(INIT_LEN - 1);

  lcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [7:0]       lcd_data_q;
  logic             lcd_rs_q;
  logic             lcd_e_q;
  logic             init_done_q;
  logic [CNT_W-1:0] wait_last;

  // Init ROM lookup.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = INIT_FUNC_SET;
      2'd1:    init_rom = INIT_DISP_ON;
      2'd2:    init_rom = INIT_CLEAR;
      2'd3:    init_rom = INIT_ENTRY;
      default: init_rom = INIT_FUNC_SET;
    endcase
  endfunction

  // Post-write wait length depends on the byte currently held on the bus.
  assign wait_last = is_long_cmd(lcd_rs_q, lcd_data_q) ? CLEAR_LAST : CMD_LAST;

  // Write sequencer FSM; all bus outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_POWERUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_POWERUP: begin
          if (cnt_q == PU_LAST) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            lcd_data_q <= init_rom(2'd0);
            lcd_rs_q   <= 1'b0;
            state_q    <= ST_SETUP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt_q == AS_LAST) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b1;
            state_q <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_PULSE: begin
          if (cnt_q == EH_LAST) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT: begin
          if (cnt_q == wait_last) begin
            cnt_q <= '0;
            // init_done low means the byte just finished came from the ROM.
            if (!init_done_q) begin
              if (idx_q == INIT_LAST) begin
                init_done_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                idx_q      <= idx_q + 2'd1;
                lcd_data_q <= init_rom(idx_q + 2'd1);
                lcd_rs_q   <= 1'b0;
                state_q    <= ST_SETUP;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          // Re-init takes priority; req_ready is low while it is asserted.
          if (soft_reinit) begin
            init_done_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            lcd_data_q  <= init_rom(2'd0);
            lcd_rs_q    <= 1'b0;
            state_q     <= ST_SETUP;
          end else if (req.req_valid) begin
            cnt_q      <= '0;
            lcd_data_q <= req.req_data;
            lcd_rs_q   <= req.req_rs;
            state_q    <= ST_SETUP;
          end
        end

        default: begin
          cnt_q   <= '0;
          lcd_e_q <= 1'b0;
          state_q <= ST_POWERUP;
        end
      endcase
    end
  end

  // Status and bus outputs.
  assign req.req_ready = (state_q == ST_IDLE) && !soft_reinit;
  assign busy          = (state_q != ST_IDLE);
  assign init_done     = init_done_q;
  assign lcd_data      = lcd_data_q;
  assign lcd_rs        = lcd_rs_q;
  assign lcd_e         = lcd_e_q;
  assign lcd_rw        = 1'b0;

endmodule
`default_nettype wire
